// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: machine word, default stage depth, NOP encoding
// and the per-stage payload bundles carried through elastic pipeline registers.
package cpu_types_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned PIPE_DEPTH = 2;

    typedef logic [XLEN-1:0] word_t;

    // addi x0, x0, 0
    localparam word_t NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        word_t instr;
        word_t npc;
    } if_id_t;

    typedef struct packed {
        word_t      npc;
        word_t      rs1_val;
        word_t      rs2_val;
        word_t      imm;
        logic [4:0] rd;
        logic [3:0] alu_op;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
    } id_ex_t;

    // A single-entry buffer still needs a 1-bit pointer to be a legal vector.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage register: small circular FIFO with valid/ready handshake,
// stage enable, synchronous flush and a saturating back-pressure counter.
module elastic_pipe_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       DEPTH   = PIPE_DEPTH,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     flush,
    input  logic                     valid_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [DATA_W-1:0]        data_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop, stall_inc;

    // ready_o is built from local state only, so no ready_i -> ready_o path exists.
    always_comb begin
        ready_o   = EN && (count_q < FULL) && !flush;
        valid_o   = (count_q != '0);
        data_o    = valid_o ? mem_q[rd_ptr_q] : NOP_VAL;
        push      = valid_i && ready_o;
        pop       = valid_o && ready_i && EN && !flush;
        stall_inc = valid_o && !(ready_i && EN);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is left unreset; count_q gates it onto data_o.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign count_o = count_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (stall_inc),
        .cnt (stall_cnt_o)
    );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: three instances (DEPTH 2, 4 with CNT_W=4, and 1).
module tb_elastic_pipe_reg;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Instance A: DEPTH=2, NOP=EE
    logic       a_en = 1'b1, a_flush = 1'b0, a_valid_i = 1'b0, a_ready_i = 1'b0;
    logic [7:0] a_data_i = '0;
    logic       a_ready_o, a_valid_o;
    logic [7:0] a_data_o;
    logic [1:0] a_count_o;
    logic [15:0] a_stall;

    // Instance B: DEPTH=4, CNT_W=4, NOP=A5
    logic       b_en = 1'b1, b_flush = 1'b0, b_valid_i = 1'b0, b_ready_i = 1'b0;
    logic [7:0] b_data_i = '0;
    logic       b_ready_o, b_valid_o;
    logic [7:0] b_data_o;
    logic [2:0] b_count_o;
    logic [3:0] b_stall;

    // Instance C: DEPTH=1
    logic       c_en = 1'b1, c_flush = 1'b0, c_valid_i = 1'b0, c_ready_i = 1'b0;
    logic [7:0] c_data_i = '0;
    logic       c_ready_o, c_valid_o;
    logic [7:0] c_data_o;
    logic [0:0] c_count_o;
    logic [7:0] c_stall;

    elastic_pipe_reg #(.DATA_W(8), .DEPTH(2), .NOP_VAL(8'hEE), .CNT_W(16)) u_a (
        .CLK(CLK), .RST(RST), .EN(a_en), .flush(a_flush), .valid_i(a_valid_i),
        .data_i(a_data_i), .ready_o(a_ready_o), .valid_o(a_valid_o), .data_o(a_data_o),
        .ready_i(a_ready_i), .count_o(a_count_o), .stall_cnt_o(a_stall)
    );

    elastic_pipe_reg #(.DATA_W(8), .DEPTH(4), .NOP_VAL(8'hA5), .CNT_W(4)) u_b (
        .CLK(CLK), .RST(RST), .EN(b_en), .flush(b_flush), .valid_i(b_valid_i),
        .data_i(b_data_i), .ready_o(b_ready_o), .valid_o(b_valid_o), .data_o(b_data_o),
        .ready_i(b_ready_i), .count_o(b_count_o), .stall_cnt_o(b_stall)
    );

    elastic_pipe_reg #(.DATA_W(8), .DEPTH(1), .NOP_VAL(8'h00), .CNT_W(8)) u_c (
        .CLK(CLK), .RST(RST), .EN(c_en), .flush(c_flush), .valid_i(c_valid_i),
        .data_i(c_data_i), .ready_o(c_ready_o), .valid_o(c_valid_o), .data_o(c_data_o),
        .ready_i(c_ready_i), .count_o(c_count_o), .stall_cnt_o(c_stall)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (a_count_o !== 2'd0 || a_valid_o !== 1'b0) begin
            fails++; $display("FAIL reset_a_cnt_valid: got %0d/%b want 0/0", a_count_o, a_valid_o);
        end
        tests++; if (a_data_o !== 8'hEE) begin
            fails++; $display("FAIL reset_a_nop: got %h want ee", a_data_o);
        end
        tests++; if (a_stall !== 16'd0 || a_ready_o !== 1'b1) begin
            fails++; $display("FAIL reset_a_stall_rdy: got %0d/%b want 0/1", a_stall, a_ready_o);
        end
        tests++; if (b_data_o !== 8'hA5 || b_count_o !== 3'd0) begin
            fails++; $display("FAIL reset_b: got %h/%0d want a5/0", b_data_o, b_count_o);
        end
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] vec [3];
        vec = '{8'h0A, 8'h0B, 8'h0C};
        a_ready_i = 1'b1;
        a_valid_i = 1'b1;
        a_data_i  = vec[0];
        tests++; if (a_ready_o !== 1'b1) begin
            fails++; $display("FAIL stream_rdy: got %b want 1", a_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            a_data_i = vec[i];
            tick();
            tests++; if (a_data_o !== vec[i] || a_valid_o !== 1'b1 || a_count_o !== 2'd1) begin
                fails++; $display("FAIL stream_%0d: got %h/%b/%0d want %h/1/1",
                                  i, a_data_o, a_valid_o, a_count_o, vec[i]);
            end
        end
        a_valid_i = 1'b0;
        tick();
        tests++; if (a_count_o !== 2'd0 || a_data_o !== 8'hEE) begin
            fails++; $display("FAIL stream_drain: got %0d/%h want 0/ee", a_count_o, a_data_o);
        end
    endtask

    task automatic test_backpressure();
        a_ready_i = 1'b0;
        a_valid_i = 1'b1;
        a_data_i  = 8'h11;
        tick();
        a_data_i = 8'h22;
        tick();
        tests++; if (a_count_o !== 2'd2 || a_ready_o !== 1'b0 || a_data_o !== 8'h11) begin
            fails++; $display("FAIL bp_full: got %0d/%b/%h want 2/0/11", a_count_o, a_ready_o, a_data_o);
        end
        a_data_i = 8'h33;
        tick();
        tests++; if (a_count_o !== 2'd2 || a_data_o !== 8'h11) begin
            fails++; $display("FAIL bp_refuse: got %0d/%h want 2/11", a_count_o, a_data_o);
        end
        a_ready_i = 1'b1;
        #1;
        tests++; if (a_ready_o !== 1'b0) begin
            fails++; $display("FAIL bp_rdy_indep: got %b want 0", a_ready_o);
        end
        tick();
        tests++; if (a_data_o !== 8'h22 || a_count_o !== 2'd1 || a_ready_o !== 1'b1) begin
            fails++; $display("FAIL bp_pop1: got %h/%0d/%b want 22/1/1", a_data_o, a_count_o, a_ready_o);
        end
        tick();
        tests++; if (a_data_o !== 8'h33 || a_count_o !== 2'd1) begin
            fails++; $display("FAIL bp_accept33: got %h/%0d want 33/1", a_data_o, a_count_o);
        end
        a_valid_i = 1'b0;
        tick();
        tests++; if (a_count_o !== 2'd0 || a_stall !== 16'd2) begin
            fails++; $display("FAIL bp_end: got %0d/%0d want 0/2", a_count_o, a_stall);
        end
    endtask

    task automatic test_en_hold();
        a_ready_i = 1'b1;
        a_valid_i = 1'b1;
        a_data_i  = 8'h44;
        tick();
        a_valid_i = 1'b0;
        a_en      = 1'b0;
        #1;
        tests++; if (a_ready_o !== 1'b0) begin
            fails++; $display("FAIL en_rdy: got %b want 0", a_ready_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (a_data_o !== 8'h44 || a_count_o !== 2'd1 || a_valid_o !== 1'b1) begin
                fails++; $display("FAIL en_hold_%0d: got %h/%0d/%b want 44/1/1",
                                  i, a_data_o, a_count_o, a_valid_o);
            end
        end
        tests++; if (a_stall !== 16'd7) begin
            fails++; $display("FAIL en_stall: got %0d want 7", a_stall);
        end
        a_en = 1'b1;
        tick();
        tests++; if (a_count_o !== 2'd0 || a_stall !== 16'd7) begin
            fails++; $display("FAIL en_resume: got %0d/%0d want 0/7", a_count_o, a_stall);
        end
        a_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        b_ready_i = 1'b0;
        b_valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b_data_i = 8'(i);
            tick();
        end
        tests++; if (b_count_o !== 3'd3 || b_ready_o !== 1'b1) begin
            fails++; $display("FAIL fl_pre: got %0d/%b want 3/1", b_count_o, b_ready_o);
        end
        b_flush  = 1'b1;
        b_data_i = 8'h55;
        #1;
        tests++; if (b_ready_o !== 1'b0) begin
            fails++; $display("FAIL fl_rdy: got %b want 0", b_ready_o);
        end
        tick();
        b_flush   = 1'b0;
        b_valid_i = 1'b0;
        tests++; if (b_count_o !== 3'd0 || b_valid_o !== 1'b0 || b_data_o !== 8'hA5) begin
            fails++; $display("FAIL fl_empty: got %0d/%b/%h want 0/0/a5", b_count_o, b_valid_o, b_data_o);
        end
        tests++; if (b_stall !== 4'd3) begin
            fails++; $display("FAIL fl_stall_kept: got %0d want 3", b_stall);
        end
        tick();
        tests++; if (b_count_o !== 3'd0) begin
            fails++; $display("FAIL fl_dropped: got %0d want 0", b_count_o);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] vec [4];
        vec = '{8'h66, 8'h77, 8'h88, 8'h99};
        b_ready_i = 1'b0;
        b_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_data_i = vec[i];
            tick();
        end
        b_valid_i = 1'b0;
        tests++; if (b_count_o !== 3'd4 || b_ready_o !== 1'b0 || b_stall !== 4'd6) begin
            fails++; $display("FAIL wr_full: got %0d/%b/%0d want 4/0/6", b_count_o, b_ready_o, b_stall);
        end
        b_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (b_data_o !== vec[i]) begin
                fails++; $display("FAIL wr_order_%0d: got %h want %h", i, b_data_o, vec[i]);
            end
            tick();
        end
        tests++; if (b_count_o !== 3'd0) begin
            fails++; $display("FAIL wr_drained: got %0d want 0", b_count_o);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp;
        b_ready_i = 1'b0;
        b_valid_i = 1'b1;
        b_data_i  = 8'hAB;
        tick();
        b_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = (7 + i > 15) ? 4'd15 : 4'(7 + i);
            tests++; if (b_stall !== exp) begin
                fails++; $display("FAIL sat_%0d: got %0d want %0d", i, b_stall, exp);
            end
        end
        tests++; if (b_data_o !== 8'hAB || b_count_o !== 3'd1) begin
            fails++; $display("FAIL sat_data: got %h/%0d want ab/1", b_data_o, b_count_o);
        end
    endtask

    task automatic test_depth1();
        logic [7:0] exp;
        c_ready_i = 1'b1;
        c_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp      = 8'h30 + 8'(i);
            c_data_i = exp;
            #1;
            tests++; if (c_ready_o !== 1'b1) begin
                fails++; $display("FAIL d1_rdy_%0d: got %b want 1", i, c_ready_o);
            end
            tick();
            tests++; if (c_data_o !== exp || c_valid_o !== 1'b1 || c_ready_o !== 1'b0) begin
                fails++; $display("FAIL d1_out_%0d: got %h/%b/%b want %h/1/0",
                                  i, c_data_o, c_valid_o, c_ready_o, exp);
            end
            tick();
        end
        c_valid_i = 1'b0;
        tests++; if (c_count_o !== 1'b0) begin
            fails++; $display("FAIL d1_empty: got %0d want 0", c_count_o);
        end
    endtask

    task automatic test_async_reset();
        a_ready_i = 1'b0;
        a_valid_i = 1'b1;
        a_data_i  = 8'h01;
        tick();
        a_data_i = 8'h02;
        tick();
        a_valid_i = 1'b0;
        tests++; if (a_count_o !== 2'd2) begin
            fails++; $display("FAIL ar_pre: got %0d want 2", a_count_o);
        end
        #3;
        RST = 1'b1;
        #1;
        tests++; if (a_count_o !== 2'd0 || a_valid_o !== 1'b0 || a_data_o !== 8'hEE) begin
            fails++; $display("FAIL ar_now: got %0d/%b/%h want 0/0/ee", a_count_o, a_valid_o, a_data_o);
        end
        tests++; if (a_stall !== 16'd0 || a_ready_o !== 1'b1) begin
            fails++; $display("FAIL ar_stall_rdy: got %0d/%b want 0/1", a_stall, a_ready_o);
        end
        #2;
        RST = 1'b0;
        a_valid_i = 1'b1;
        a_data_i  = 8'h07;
        tick();
        a_valid_i = 1'b0;
        tests++; if (a_data_o !== 8'h07 || a_count_o !== 2'd1 || a_valid_o !== 1'b1) begin
            fails++; $display("FAIL ar_push: got %h/%0d/%b want 07/1/1", a_data_o, a_count_o, a_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_en_hold();
        test_flush();
        test_wrap();
        test_saturate();
        test_depth1();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
